// File: rtl/fsm_col_sel_circuit_pkg.sv
// Shared constants and types for the 4x4 Connect-4 controller: state/status codes,
// player constants and the ten win-line masks.
package connect4_pkg;

  localparam int unsigned NUM_COLS  = 4;
  localparam int unsigned NUM_ROWS  = 4;
  localparam int unsigned NUM_CELLS = NUM_COLS * NUM_ROWS;
  localparam int unsigned NUM_LINES = 10;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLACE = 2'b01,
    ST_CHECK = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    GS_PLAYING = 2'b00,
    GS_P1_WIN  = 2'b01,
    GS_P2_WIN  = 2'b10,
    GS_TIE     = 2'b11
  } status_t;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  // Column-select result: target cell plus invalid flag in the MSB
  typedef struct packed {
    logic             invalid;
    logic [IDX_W-1:0] idx;
  } col_calc_t;

  // Rows, columns, then the two diagonals
  localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] WIN_MASKS = {
    16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
    16'h1111, 16'h2222, 16'h4444, 16'h8888,
    16'h8421, 16'h1248
  };

endpackage

// File: rtl/fsm_col_sel_circuit_if.sv
// Move-request and game-state bundle between the controller and its driver/display.
interface fsm_col_sel_circuit_if;
  import connect4_pkg::*;

  logic                 enable;
  logic [NUM_COLS-1:0]  in_column;
  logic [NUM_CELLS-1:0] out_gameboard;
  logic [NUM_CELLS-1:0] out_players_cells;
  logic [1:0]           out_game_status;
  logic [1:0]           current_state;
  logic                 playerTurn;
  logic [IDX_W:0]       column_calc;

  modport master (
    output enable, in_column,
    input  out_gameboard, out_players_cells, out_game_status,
    input  current_state, playerTurn, column_calc
  );

  modport slave (
    input  enable, in_column,
    output out_gameboard, out_players_cells, out_game_status,
    output current_state, playerTurn, column_calc
  );

endinterface

// File: rtl/fsm_col_sel_circuit_win_checker.sv
// Combinational four-in-a-line detector for one player over the ten win lines.
module c4_win_checker
  import connect4_pkg::*;
(
  input  logic [NUM_CELLS-1:0] board,
  input  logic [NUM_CELLS-1:0] owner,
  input  logic                 player,
  output logic                 win
);

  logic [NUM_CELLS-1:0] w_cells;

  assign w_cells = board & (player ? owner : ~owner);

  always_comb begin
    win = 1'b0;
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      if ((w_cells & WIN_MASKS[i]) == WIN_MASKS[i]) win = 1'b1;
    end
  end

endmodule

// File: rtl/fsm_col_sel_circuit.sv
// Connect-4 game controller: column decode, piece placement, win/tie detection
// and turn sequencing on a fixed 4x4 board.
module fsm_col_sel_circuit
  import connect4_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  fsm_col_sel_circuit_if.slave bus
);

  state_t               r_state, w_state_nxt;
  status_t              r_status, w_status_nxt;
  logic [NUM_CELLS-1:0] r_board, w_board_nxt;
  logic [NUM_CELLS-1:0] r_owner, w_owner_nxt;
  logic                 r_turn, w_turn_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;

  col_calc_t            w_calc;
  logic                 w_col_valid;
  logic                 w_found;
  logic [1:0]           w_col;
  logic                 w_win;

  // Decode active-low one-hot select and find the lowest empty cell in that column
  always_comb begin
    w_col_valid = 1'b1;
    w_col       = 2'd0;
    w_found     = 1'b0;
    w_calc      = '0;
    case (bus.in_column)
      4'b1110: w_col = 2'd0;
      4'b1101: w_col = 2'd1;
      4'b1011: w_col = 2'd2;
      4'b0111: w_col = 2'd3;
      default: w_col_valid = 1'b0;
    endcase
    for (int row = int'(NUM_ROWS) - 1; row >= 0; row--) begin
      if (!r_board[row * int'(NUM_COLS) + int'(w_col)]) begin
        w_found    = 1'b1;
        w_calc.idx = IDX_W'(row * int'(NUM_COLS) + int'(w_col));
      end
    end
    if (!w_col_valid || !w_found) begin
      w_calc.invalid = 1'b1;
      w_calc.idx     = '0;
    end
  end

  c4_win_checker u_win_checker (
    .board  (r_board),
    .owner  (r_owner),
    .player (r_turn),
    .win    (w_win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_status <= GS_PLAYING;
      r_board  <= '0;
      r_owner  <= '0;
      r_turn   <= PLAYER_1;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      r_board  <= w_board_nxt;
      r_owner  <= w_owner_nxt;
      r_turn   <= w_turn_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_board_nxt  = r_board;
    w_owner_nxt  = r_owner;
    w_turn_nxt   = r_turn;
    w_idx_nxt    = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable && !w_calc.invalid) begin
          w_idx_nxt   = w_calc.idx;
          w_state_nxt = ST_PLACE;
        end
      end
      ST_PLACE: begin
        w_board_nxt[r_idx] = 1'b1;
        w_owner_nxt[r_idx] = r_turn;
        w_state_nxt        = ST_CHECK;
      end
      ST_CHECK: begin
        // A line completed by the last piece beats a full-board tie
        if (w_win) begin
          if (r_turn == PLAYER_2) w_status_nxt = GS_P2_WIN;
          else                    w_status_nxt = GS_P1_WIN;
          w_state_nxt = ST_OVER;
        end else if (&r_board) begin
          w_status_nxt = GS_TIE;
          w_state_nxt  = ST_OVER;
        end else begin
          w_turn_nxt  = ~r_turn;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OVER: w_state_nxt = ST_OVER;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.out_gameboard     = r_board;
  assign bus.out_players_cells = r_owner;
  assign bus.out_game_status   = r_status;
  assign bus.current_state     = r_state;
  assign bus.playerTurn        = r_turn;
  assign bus.column_calc       = w_calc;

endmodule

// File: tb/tb_fsm_col_sel_circuit.sv
// Directed bench for the Connect-4 controller: vertical win, diagonal win, tie,
// invalid/full-column requests and asynchronous reset in mid-move.
module tb_fsm_col_sel_circuit;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  int   seq_vert [7]  = '{0, 1, 0, 2, 0, 2, 0};
  int   seq_diag [10] = '{1, 0, 2, 1, 2, 2, 3, 3, 3, 3};
  int   seq_tie  [16] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3, 0, 2, 1, 3};

  fsm_col_sel_circuit_if bus ();

  fsm_col_sel_circuit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] board, input logic [15:0] owner,
                         input logic [1:0] status, input logic [1:0] state, input logic turn);
    chk({tag, "_board"},  bus.out_gameboard,            board);
    chk({tag, "_owner"},  bus.out_players_cells,        owner);
    chk({tag, "_status"}, 16'(bus.out_game_status),     16'(status));
    chk({tag, "_state"},  16'(bus.current_state),       16'(state));
    chk({tag, "_turn"},   16'(bus.playerTurn),          16'(turn));
  endtask

  function automatic logic [3:0] col_sel(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  // Enable for one edge, then wait for the full PLACE/CHECK latency
  task automatic do_move(input int c);
    bus.in_column = col_sel(c);
    bus.enable    = 1'b1;
    @(posedge clk); #1;
    bus.enable    = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.in_column = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    bus.in_column = 4'b1110;
    #1 chk("calc_c0_empty", 16'(bus.column_calc), 16'(5'b00000));
    bus.in_column = 4'b1101;
    #1 chk("calc_c1_empty", 16'(bus.column_calc), 16'(5'b00001));
    chk_all("idle", 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0);

    // Vertical P1 win in column 0
    do_move(seq_vert[0]);
    chk_all("vert_m1", 16'h0001, 16'h0000, 2'b00, 2'b00, 1'b1);
    for (int i = 1; i < 7; i++) do_move(seq_vert[i]);
    chk_all("vert_win", 16'h1157, 16'h0046, 2'b01, 2'b11, 1'b0);
    do_move(2);
    do_move(0);
    chk_all("vert_frozen", 16'h1157, 16'h0046, 2'b01, 2'b11, 1'b0);

    // Diagonal P2 win
    do_reset();
    chk_all("diag_reset", 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) do_move(seq_diag[i]);
    chk_all("diag_win", 16'h8CEF, 16'h84A1, 2'b10, 2'b11, 1'b1);
    chk("diag_cells", bus.out_players_cells & 16'h8421, 16'h8421);

    // Full board without a line
    do_reset();
    for (int i = 0; i < 15; i++) do_move(seq_tie[i]);
    chk_all("tie_m15", 16'h7FFF, 16'h4A5A, 2'b00, 2'b00, 1'b1);
    do_move(seq_tie[15]);
    chk_all("tie_end", 16'hFFFF, 16'hCA5A, 2'b11, 2'b11, 1'b1);

    // Invalid selects and full column
    do_reset();
    bus.in_column = 4'b1100;
    bus.enable    = 1'b1;
    #1 chk("calc_two_low", 16'(bus.column_calc), 16'(5'b10000));
    repeat (2) @(posedge clk);
    #1 chk_all("inv_two_low", 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0);
    bus.in_column = 4'b1111;
    #1 chk("calc_none_low", 16'(bus.column_calc), 16'(5'b10000));
    repeat (2) @(posedge clk);
    #1 chk_all("inv_none_low", 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0);
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) do_move(0);
    chk_all("col0_full", 16'h1111, 16'h1010, 2'b00, 2'b00, 1'b0);
    bus.in_column = 4'b1110;
    #1 chk("calc_full_col", 16'(bus.column_calc), 16'(5'b10000));
    do_move(0);
    chk_all("full_col_ignored", 16'h1111, 16'h1010, 2'b00, 2'b00, 1'b0);
    bus.in_column = 4'b0111;
    #1 chk("calc_c3", 16'(bus.column_calc), 16'(5'b00011));

    // Async reset while in PLACE
    do_move(1);
    chk_all("pre_abort", 16'h1113, 16'h1010, 2'b00, 2'b00, 1'b1);
    bus.in_column = 4'b1011;
    bus.enable    = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_place", 16'(bus.current_state), 16'(2'b01));
    bus.enable = 1'b0;
    #2 reset = 1'b0;
    #1 chk_all("abort_async", 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_all("abort_after", 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
